// File: rtl/parser_pkg.sv
// Shared types and width helpers for the parser ingress arbiter.
package parser_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_FLUSH
    } arb_state_t;

    localparam int PKT_CNT_W   = 32;
    localparam int ABORT_CNT_W = 16;

    function automatic int idx_width(input int data_width);
        return $clog2(data_width / 8 + 1);
    endfunction

    function automatic int port_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/parser_ingress_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found scanning from ptr upward, wrapping.
module rr_pick
    import parser_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PW        = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [PW-1:0]        gnt_idx,
    output logic                 any
);

    logic found;
    int   cand;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/parser_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared parser chain.
// Optional per-port packet/abort counters are enabled with PARSER_ARB_STATS_EN.
module parser_ingress_arbiter
    import parser_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    parameter int  NUM_PORTS  = 2,
    parameter int  MAX_BEATS  = 192,
    localparam int IDXW       = idx_width(DATA_WIDTH),
    localparam int PW         = port_width(NUM_PORTS),
    localparam int BCW        = cnt_width(MAX_BEATS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*IDXW-1:0]       s_idx,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS-1:0]            s_last,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [IDXW-1:0]                 m_idx,
    output logic                            m_valid,
    output logic                            m_last,
    output logic                            m_sop,
    output logic [PW-1:0]                   m_port,
    input  logic                            m_ready,
    output logic                            abort,
    output logic                            busy
`ifdef PARSER_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*PKT_CNT_W-1:0]   pkt_cnt,
    output logic [NUM_PORTS*ABORT_CNT_W-1:0] abort_cnt
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IDXW-1:0]       idx;
        logic                  last;
    } beat_t;

    arb_state_t     state, state_nx;
    logic [PW-1:0]  grant, rr_ptr, pick_idx, grant_inc;
    logic           pick_any;
    logic [BCW-1:0] beat_cnt;
    beat_t          sel;
    logic           sel_valid, load_en, accept, at_max;
    logic           xfer_acc, trunc, done;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .req     (s_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        sel.data  = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        sel.idx   = s_idx[int'(grant)*IDXW +: IDXW];
        sel.last  = s_last[grant];
        sel_valid = s_valid[grant];
    end

    assign load_en   = !m_valid || m_ready;
    assign at_max    = (beat_cnt == BCW'(MAX_BEATS - 1));
    assign grant_inc = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
    assign busy      = (state != ARB_IDLE);

    always_comb begin
        state_nx = state;
        s_ready  = '0;
        accept   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_nx = ARB_XFER;
            end
            ARB_XFER: begin
                s_ready[grant] = load_en;
                accept         = sel_valid && load_en;
                if (accept) begin
                    if (sel.last)    state_nx = ARB_IDLE;
                    else if (at_max) state_nx = ARB_FLUSH;
                end
            end
            ARB_FLUSH: begin
                // Drain the runaway packet without touching the output register.
                s_ready[grant] = 1'b1;
                accept         = sel_valid;
                if (accept && sel.last) state_nx = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    assign xfer_acc = (state == ARB_XFER) && accept;
    assign trunc    = xfer_acc && !sel.last && at_max;
    assign done     = accept && sel.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ARB_IDLE && pick_any) grant <= pick_idx;
            if (done) begin
                rr_ptr   <= grant_inc;
                beat_cnt <= '0;
            end else if (trunc) begin
                beat_cnt <= '0;
            end else if (xfer_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Output stage: one register slice toward the eth parser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata <= '0;
            m_idx   <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_sop   <= 1'b0;
            m_port  <= '0;
            abort   <= 1'b0;
        end else begin
            abort <= trunc;
            if (load_en) begin
                m_valid <= xfer_acc;
                if (xfer_acc) begin
                    m_tdata <= sel.data;
                    m_idx   <= sel.idx;
                    m_last  <= sel.last || at_max;
                    m_sop   <= (beat_cnt == '0);
                    m_port  <= grant;
                end
            end
        end
    end

`ifdef PARSER_ARB_STATS_EN
    function automatic logic [PKT_CNT_W-1:0] sat_inc_pkt(input logic [PKT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ABORT_CNT_W-1:0] sat_inc_abort(input logic [ABORT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            if (xfer_acc && sel.last)
                pkt_cnt[int'(grant)*PKT_CNT_W +: PKT_CNT_W] <=
                    sat_inc_pkt(pkt_cnt[int'(grant)*PKT_CNT_W +: PKT_CNT_W]);
            if (trunc)
                abort_cnt[int'(grant)*ABORT_CNT_W +: ABORT_CNT_W] <=
                    sat_inc_abort(abort_cnt[int'(grant)*ABORT_CNT_W +: ABORT_CNT_W]);
        end
    end
`endif

endmodule
